// File: rtl/serial1s_pkg.sv
// Shared types and sizing for the ones-counting serial front end.
package serial1s_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int WIDTH_DEFAULT = 8;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/serial1s_deser_if.sv
// Serial input stream plus valid/ready word output toward the popcount stage.
interface serial1s_deser_if #(parameter int WIDTH = serial1s_pkg::WIDTH_DEFAULT);
  logic             sin_valid;
  logic             sin;
  logic             sin_start;
  logic [WIDTH-1:0] a;
  logic             a_valid;
  logic             a_ready;
  logic             overrun;
  logic [7:0]       words;

  modport master (output sin_valid, sin, sin_start, a_ready,
                  input  a, a_valid, overrun, words);
  modport slave  (input  sin_valid, sin, sin_start, a_ready,
                  output a, a_valid, overrun, words);
endinterface

// File: rtl/serial1s_shreg.sv
// Shift register and bit counter; flags the shift that completes a word.
module serial1s_shreg
  import serial1s_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             restart,
  input  logic             din,
  output logic             done,
  output logic [WIDTH-1:0] word
);
  localparam int CW = cnt_w(WIDTH);

  // The oldest bit is never needed again once the word completes, so only
  // WIDTH-1 bits are stored; the incoming bit supplies the LSB of word.
  logic [WIDTH-2:0] shreg;
  logic [CW-1:0]    count;

  assign word = {shreg, din};
  assign done = shift && !restart && (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      count <= '0;
    end else if (shift) begin
      if (restart) begin
        shreg <= {{(WIDTH-2){1'b0}}, din};
        count <= CW'(1);
      end else begin
        shreg <= word[WIDTH-2:0];
        count <= done ? '0 : count + 1'b1;
      end
    end
  end
endmodule

// File: rtl/serial1s_deser.sv
// Framing FSM, one-word output holding register, overrun flag and word count.
module serial1s_deser
  import serial1s_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  serial1s_deser_if.slave  bus
);
  state_t           state, state_nxt;
  logic             shift, restart, done, take;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] a_q;
  logic             a_valid_q, overrun_q;
  logic [7:0]       words_q;

  serial1s_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .shift   (shift),
    .restart (restart),
    .din     (bus.sin),
    .done    (done),
    .word    (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    restart   = 1'b0;
    case (state)
      IDLE: if (bus.sin_valid && bus.sin_start) begin
        shift     = 1'b1;
        restart   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: if (bus.sin_valid) begin
        shift   = 1'b1;
        restart = bus.sin_start;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A completing word is taken if the holder is empty or drains this edge.
  assign take = done && (!a_valid_q || bus.a_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      a_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      words_q   <= '0;
    end else begin
      if (take) begin
        a_q       <= word;
        a_valid_q <= 1'b1;
        words_q   <= words_q + 8'd1;
      end else if (a_valid_q && bus.a_ready) begin
        a_valid_q <= 1'b0;
      end
      if (done && !take) overrun_q <= 1'b1;
    end
  end

  assign bus.a       = a_q;
  assign bus.a_valid = a_valid_q;
  assign bus.overrun = overrun_q;
  assign bus.words   = words_q;
endmodule

// File: tb/tb_serial1s_deser.sv
// Scoreboard bench: directed framing scenarios followed by random streams.
module tb_serial1s_deser;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial1s_deser_if #(.WIDTH(W)) bus();

  serial1s_deser #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits of the current frame kept as a list; a word is
  // complete once W bits have been gathered since the last start.
  bit         cur[$];
  bit         framed;
  bit         m_held, m_ovr;
  int         m_words;
  logic [W-1:0] exp_q[$];
  logic [7:0] last_words;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cur.delete();
      framed = 0; m_held = 0; m_ovr = 0; m_words = 0;
      exp_q.delete();
      last_words = 8'd0;
    end else begin
      bit done;
      int wv;
      done = 0;
      wv = 0;
      if (bus.sin_valid) begin
        if (bus.sin_start) begin
          cur.delete();
          cur.push_back(bus.sin);
          framed = 1;
        end else if (framed) begin
          cur.push_back(bus.sin);
        end
        if (cur.size() == W) begin
          foreach (cur[i]) wv = wv * 2 + int'(cur[i]);
          cur.delete();
          done = 1;
        end
      end
      if (done && (!m_held || bus.a_ready)) begin
        exp_q.push_back(W'(wv));
        m_held = 1;
        m_words = (m_words + 1) % 256;
      end else begin
        if (done) m_ovr = 1;
        if (bus.a_ready) m_held = 0;
      end
    end
  end

  // Monitor: every load (words steps) pops one expected word.
  always @(negedge clk) begin
    if (!reset) begin
      chk("a_valid", 32'(bus.a_valid), 32'(m_held));
      chk("overrun", 32'(bus.overrun), 32'(m_ovr));
      chk("words", 32'(bus.words), 32'(m_words));
      if (bus.words != last_words) begin
        last_words = bus.words;
        checks++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_word: got %0h expected none", bus.a);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          checks--;
          chk("a_word", 32'(bus.a), 32'(e));
        end
      end
    end
  end

  task automatic send_bit(input bit v, input bit b, input bit s);
    bus.sin_valid = v;
    bus.sin       = b;
    bus.sin_start = s;
    @(posedge clk); #1;
    bus.sin_valid = 1'b0;
    bus.sin_start = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit start);
    for (int i = 0; i < W; i++) send_bit(1'b1, w[W-1-i], start && (i == 0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_a", 32'(bus.a), 32'h0);
    chk("rst_a_valid", 32'(bus.a_valid), 32'h0);
    chk("rst_overrun", 32'(bus.overrun), 32'h0);
    chk("rst_words", 32'(bus.words), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.sin_valid = 1'b0; bus.sin = 1'b0; bus.sin_start = 1'b0; bus.a_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Basic framed word, accepted immediately
    send_word(8'b10110010, 1'b1);
    chk("t1_a", 32'(bus.a), 32'hB2);
    chk("t1_valid", 32'(bus.a_valid), 32'h1);
    chk("t1_words", 32'(bus.words), 32'h1);
    send_bit(1'b0, 1'b0, 1'b0);
    chk("t1_pulse", 32'(bus.a_valid), 32'h0);

    // Unframed bits in IDLE ignored
    do_reset();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1, 1'b0);
    send_word(8'hFF, 1'b1);
    chk("t2_a", 32'(bus.a), 32'hFF);
    chk("t2_words", 32'(bus.words), 32'h1);

    // Resync drops a partial word
    do_reset();
    send_bit(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0);
    send_word(8'h0F, 1'b1);
    chk("t3_a", 32'(bus.a), 32'h0F);
    chk("t3_words", 32'(bus.words), 32'h1);

    // Back-pressure: second word dropped
    do_reset();
    bus.a_ready = 1'b0;
    send_word(8'hA5, 1'b1);
    send_word(8'h3C, 1'b0);
    chk("t4_a", 32'(bus.a), 32'hA5);
    chk("t4_overrun", 32'(bus.overrun), 32'h1);
    chk("t4_words", 32'(bus.words), 32'h1);
    bus.a_ready = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);
    chk("t4_drain", 32'(bus.a_valid), 32'h0);

    // Accept coincident with completion: no bubble, no overrun
    do_reset();
    bus.a_ready = 1'b0;
    send_word(8'h7E, 1'b1);
    for (int i = 0; i < W - 1; i++) send_bit(1'b1, 8'h81 >> (W - 1 - i), 1'b0);
    bus.a_ready = 1'b1;
    send_bit(1'b1, 1'b1, 1'b0);
    chk("t5_a", 32'(bus.a), 32'h81);
    chk("t5_valid", 32'(bus.a_valid), 32'h1);
    chk("t5_overrun", 32'(bus.overrun), 32'h0);
    chk("t5_words", 32'(bus.words), 32'h2);

    // Reset mid-word with a pending word
    do_reset();
    bus.a_ready = 1'b0;
    send_word(8'h11, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < W; i++) send_bit(1'b1, 1'b1, 1'b0);
    chk("t6_ignored_words", 32'(bus.words), 32'h0);
    chk("t6_ignored_valid", 32'(bus.a_valid), 32'h0);
    bus.a_ready = 1'b1;
    send_word(8'h55, 1'b1);
    chk("t6_a", 32'(bus.a), 32'h55);
    chk("t6_words", 32'(bus.words), 32'h1);

    // Random streams with random back-pressure and occasional resets
    for (int n = 0; n < 1500; n++) begin
      bus.a_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1; #2; reset = 1'b0;
      end
      send_bit($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 11) == 0);
    end

    @(negedge clk); #1;
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
